// File: rtl/register_bank_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register_bank_mp                                             |
// | Description : MIPS architectural register file with bypassed read ports,   |
// |               a debug read port and a handshaked sequential dump engine.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module register_bank_mp #(
  parameter int BITS_REGS   = 5,
  parameter int BITS_SIZE   = 32,
  parameter int REG_SIZE    = 32,
  parameter int R0_ZERO     = 1,
  parameter int RESET_INDEX = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_flag_regWrite,
  input  logic [BITS_REGS-1:0] i_addr_rs,
  input  logic [BITS_REGS-1:0] i_addr_rt,
  input  logic [BITS_REGS-1:0] i_addr_rd,
  input  logic [BITS_SIZE-1:0] i_data_write,
  input  logic [BITS_REGS-1:0] i_addr_unitdebug,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  output logic [BITS_SIZE-1:0] o_rs,
  output logic [BITS_SIZE-1:0] o_rt,
  output logic [BITS_SIZE-1:0] o_reg_unitdebug,
  output logic                 o_dump_valid,
  output logic [BITS_REGS-1:0] o_dump_addr,
  output logic [BITS_SIZE-1:0] o_dump_data,
  output logic                 o_dump_busy,
  output logic                 o_dump_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } dump_state_t;

  dump_state_t          r_state;
  dump_state_t          w_state_next;
  logic [BITS_SIZE-1:0] r_regs [REG_SIZE];
  logic [BITS_REGS-1:0] r_dump_addr;
  logic [BITS_SIZE-1:0] r_dump_data;
  logic                 w_rd_is_zero;
  logic                 w_we;
  logic                 w_load;
  logic                 w_last;
  logic [BITS_REGS-1:0] w_next_addr;
  logic [BITS_SIZE-1:0] w_next_data;

  // Value a register holds after the current edge: zero register, same-cycle write, or stored value.
  function automatic logic [BITS_SIZE-1:0] f_read(
    input logic [BITS_REGS-1:0] addr,
    input logic [BITS_SIZE-1:0] stored,
    input logic                 we,
    input logic [BITS_REGS-1:0] waddr,
    input logic [BITS_SIZE-1:0] wdata
  );
    if ((R0_ZERO != 0) && (addr == '0)) return '0;
    if (we && (addr == waddr)) return wdata;
    return stored;
  endfunction

  assign w_rd_is_zero = (R0_ZERO != 0) && (i_addr_rd == '0);
  assign w_we         = i_flag_regWrite & i_step & ~w_rd_is_zero;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        r_regs[i] <= (RESET_INDEX != 0) ? BITS_SIZE'(i) : '0;
      end
    end else if (w_we) begin
      r_regs[i_addr_rd] <= i_data_write;
    end
  end

  assign o_rs            = f_read(i_addr_rs, r_regs[i_addr_rs], w_we, i_addr_rd, i_data_write);
  assign o_rt            = f_read(i_addr_rt, r_regs[i_addr_rt], w_we, i_addr_rd, i_data_write);
  assign o_reg_unitdebug = f_read(i_addr_unitdebug, r_regs[i_addr_unitdebug], w_we, i_addr_rd,
                                  i_data_write);

  assign w_last = (r_dump_addr == BITS_REGS'(REG_SIZE - 1));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_next_addr  = r_dump_addr + BITS_REGS'(1);
    case (r_state)
      S_IDLE: begin
        if (i_dump_start) begin
          w_load       = 1'b1;
          w_next_addr  = '0;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (i_dump_ready) begin
          if (w_last) w_state_next = S_DONE;
          else        w_load       = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_next_data = f_read(w_next_addr, r_regs[w_next_addr], w_we, i_addr_rd, i_data_write);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_dump_addr <= '0;
      r_dump_data <= '0;
    end else begin
      r_state <= w_state_next;
      // Beat contents are captured once per load so later writes cannot disturb a stalled beat.
      if (w_load) begin
        r_dump_addr <= w_next_addr;
        r_dump_data <= w_next_data;
      end
    end
  end

  assign o_dump_valid = (r_state == S_SEND);
  assign o_dump_busy  = (r_state != S_IDLE);
  assign o_dump_done  = (r_state == S_DONE);
  assign o_dump_addr  = r_dump_addr;
  assign o_dump_data  = r_dump_data;

endmodule
`default_nettype wire

// File: doc/register_bank_mp.md
# register_bank_mp

Parametrised architectural register file for the MIPS pipeline: two combinational read ports with same-cycle write-to-read bypass, one write port gated by the debug step enable, and an optional hard-wired zero register. The block also provides a random-access debug read port and a handshaked sequential dump engine that streams every register to the debug unit for display. It sits between the decode stage (reads) and write-back (write), with the dump channel wired to the debug unit.

## Interface
- BITS_REGS, 5, register address width
- BITS_SIZE, 32, register data width
- REG_SIZE, 32, number of registers; must equal 2**BITS_REGS
- R0_ZERO, 1, 1: register 0 reads as zero and ignores writes
- RESET_INDEX, 1, 1: register i resets to value i; 0: all registers reset to zero

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_step  in  1  write enable qualifier from the debug unit
- i_flag_regWrite  in  1  write request from write-back
- i_addr_rs  in  BITS_REGS  read port A address
- i_addr_rt  in  BITS_REGS  read port B address
- i_addr_rd  in  BITS_REGS  write address
- i_data_write  in  BITS_SIZE  write data
- i_addr_unitdebug  in  BITS_REGS  debug random-access address
- i_dump_start  in  1  single-cycle request to stream all registers
- i_dump_ready  in  1  debug unit accepts the current dump beat
- o_rs  out  BITS_SIZE  read port A data
- o_rt  out  BITS_SIZE  read port B data
- o_reg_unitdebug  out  BITS_SIZE  debug random-access data
- o_dump_valid  out  1  dump beat present
- o_dump_addr  out  BITS_REGS  register index of current beat
- o_dump_data  out  BITS_SIZE  register value of current beat
- o_dump_busy  out  1  dump engine not idle
- o_dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Write enable we = i_flag_regWrite & i_step & !(R0_ZERO & i_addr_rd==0); on rising edge with we, reg[i_addr_rd] <= i_data_write.
- Reads (rs, rt, unitdebug) are combinational: if we and address == i_addr_rd, return i_data_write (bypass), else reg[address]. With R0_ZERO, address 0 always returns 0, bypass never applies.
- Dump FSM states IDLE, SEND, DONE:
  - IDLE: o_dump_valid=0, busy=0. On i_dump_start: addr<=0, data<=post-edge value of reg[0] (includes a same-edge write), valid<=1, go SEND.
  - SEND: valid=1; addr/data held stable while i_dump_ready=0. On valid&ready: if addr==REG_SIZE-1, valid<=0, go DONE; else addr<=addr+1, data<=post-edge value of reg[addr+1] (bypass if written same edge), stay.
  - DONE: o_dump_done=1 for exactly one cycle, busy=1, then IDLE.
- i_dump_start outside IDLE is ignored. Writes to a register after its beat was loaded do not alter the presented o_dump_data.
- i_step gates writes only; reads and dump run regardless.

## Timing
- Reset (asynchronous assertion, synchronous release on next edge): reg[i]=i if RESET_INDEX else 0 (reg[0]=0 when R0_ZERO); FSM IDLE; o_dump_valid=0, o_dump_addr=0, o_dump_data=0, o_dump_busy=0, o_dump_done=0. o_rs/o_rt/o_reg_unitdebug reflect reset contents combinationally.
- Reset mid-dump aborts immediately: valid, busy, done low; no done pulse.
- Read latency 0; write visible on reads via bypass in the same cycle, from the array the cycle after.
- Dump: start sampled at edge k -> first beat valid after edge k; with ready held high, beats at cycles k+1..k+REG_SIZE, o_dump_done high in cycle k+REG_SIZE+1, busy low from cycle k+REG_SIZE+2.
- Address arithmetic is BITS_REGS wide; o_dump_addr never wraps past REG_SIZE-1 during a dump.

## Test plan
- Reset, RESET_INDEX=1: i_addr_rs=7, i_addr_rt=31 -> o_rs=7, o_rt=31; address 0 -> 0.
- Write rd=5, data 0xDEADBEEF, step=1, rs=5 same cycle -> o_rs=0xDEADBEEF (bypass); next cycle, write off, still 0xDEADBEEF. Repeat with step=0 -> reg 5 stays 5, no bypass.
- R0_ZERO: write rd=0 data 0x1234, step=1 -> o_rs(rs=0)=0 same and next cycle.
- Dump with ready tied 1 after reset -> 32 beats addr 0..31, data 0..31, done pulse in cycle 33 after start, busy low cycle 34; second start while busy ignored.
- Dump with ready toggling 1-0 and write to reg 3 (0xA5A5A5A5) while beat 3 stalled -> beat 3 shows 3 held stable; write to reg 4 during beat 3 -> beat 4 shows 0xA5A5A5A5-style new value.
- Assert i_reset at beat 10 -> valid/busy low immediately, no done pulse, registers back to index values.
